// File: rtl/seq_mult_pkg.sv
// Shared types and sizing helpers for the seq_mult shift-and-add multiplier.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int unsigned WIDTH_MIN = 2;
    localparam int unsigned WIDTH_MAX = 32;

    // Counter must reach WIDTH-1 and be compared against it.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/seq_mult_add.sv
// WIDTH-bit ripple adder with carry out, built from half/full adder bit cells.
module seq_mult_add #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:1] carry;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i == 0) begin : g_ha
            assign sum[i]       = a[i] ^ b[i];
            assign carry[i + 1] = a[i] & b[i];
        end else begin : g_fa
            assign sum[i]       = a[i] ^ b[i] ^ carry[i];
            assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = carry[WIDTH];

endmodule

// File: rtl/seq_mult.sv
// Sequential shift-and-add multiplier, one partial product per cycle.
// Define SEQ_MULT_SIGNED_EN for two's-complement operands and product.
module seq_mult
    import seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int unsigned CW = cnt_width(WIDTH);
    localparam int unsigned PW = 2 * WIDTH;

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("seq_mult: WIDTH out of range");
    end

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  mcand_q, mcand_d;
    logic [WIDTH-1:0]  mplier_q, mplier_d;
    logic [WIDTH-1:0]  acc_hi_q, acc_hi_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     product_q, product_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [PW-1:0]     prod_raw;

    logic [WIDTH-1:0]  add_b;
    logic [WIDTH-1:0]  add_sum;
    logic              add_cout;

`ifdef SEQ_MULT_SIGNED_EN
    logic              neg_q, neg_d;

    // Magnitude of a two's-complement value; -2^(WIDTH-1) maps to 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? WIDTH'(~v + 1'b1) : v;
    endfunction
`endif

    assign add_b = mplier_q[0] ? mcand_q : '0;

    seq_mult_add #(.WIDTH(WIDTH)) u_add (
        .a    (acc_hi_q),
        .b    (add_b),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_hi_d  = acc_hi_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        prod_raw  = '0;
`ifdef SEQ_MULT_SIGNED_EN
        neg_d     = neg_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
`ifdef SEQ_MULT_SIGNED_EN
                    mcand_d  = mag(a);
                    mplier_d = mag(b);
                    neg_d    = a[WIDTH-1] ^ b[WIDTH-1];
`else
                    mcand_d  = a;
                    mplier_d = b;
`endif
                    acc_hi_d = '0;
                    cnt_d    = '0;
                    state_d  = ST_RUN;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Shift {carry, sum, mplier} right by one; carry lands in acc_hi MSB.
                acc_hi_d = {add_cout, add_sum[WIDTH-1:1]};
                mplier_d = {add_sum[0], mplier_q[WIDTH-1:1]};
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    prod_raw = {acc_hi_d, mplier_d};
`ifdef SEQ_MULT_SIGNED_EN
                    product_d = neg_q ? PW'(~prod_raw + 1'b1) : prod_raw;
`else
                    product_d = prod_raw;
`endif
                    state_d   = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_hi_q  <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
            neg_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_hi_q  <= acc_hi_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef SEQ_MULT_SIGNED_EN
            neg_q     <= neg_d;
`endif
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_seq_mult.sv
// Directed self-checking bench for seq_mult at WIDTH=8 (signed vectors under SEQ_MULT_SIGNED_EN).
module tb_seq_mult;

    localparam int unsigned W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int total = 0;
    int bad   = 0;

    seq_mult #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib);
        start = 1'b1;
        a     = ia;
        b     = ib;
    endtask

    // Accepting edge, then count cycles to done; optional start pokes during RUN
    // and an optional chained start held through the DONE cycle.
    task automatic await_done(input string tag, input logic [2*W-1:0] exp,
                              input logic [7:0] poke_mask, input bit chain,
                              input logic [W-1:0] ca, input logic [W-1:0] cb);
        int n;
        int busy_cnt;
        n = 0;
        busy_cnt = 0;
        @(posedge clk);
        #1;
        start = 1'b0;
        while (!done && n < 40) begin
            if (busy) busy_cnt++;
            if (n < 8 && poke_mask[n]) begin
                start = 1'b1;
                a     = 8'd1;
                b     = 8'd1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'd8);
        check({tag, " busy_cycles"}, 32'(busy_cnt), 32'd8);
        check({tag, " busy_in_done"}, 32'(busy), 32'd0);
        check({tag, " product"}, 32'(product), 32'(exp));
        if (chain) issue(ca, cb);
    endtask

    task automatic idle_watch(input string tag, input int cycles, input logic [2*W-1:0] exp);
        int pulses;
        pulses = 0;
        start = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check({tag, " extra_done"}, 32'(pulses), 32'd0);
        check({tag, " product_hold"}, 32'(product), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset product", 32'(product), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        issue(8'd13, 8'd11);
        await_done("13x11", 16'd143, 8'h00, 1'b0, '0, '0);
        idle_watch("13x11", 3, 16'd143);

        issue(8'd255, 8'd255);
        await_done("255x255", 16'hFE01, 8'h00, 1'b0, '0, '0);
        idle_watch("255x255", 2, 16'hFE01);

        issue(8'd0, 8'hA5);
        await_done("0xA5", 16'd0, 8'h00, 1'b0, '0, '0);

        // start pokes ahead of iterations 3 and 5 must be ignored
        issue(8'd7, 8'd9);
        await_done("7x9 ignore", 16'd63, 8'b0001_0100, 1'b0, '0, '0);
        idle_watch("7x9 ignore", 12, 16'd63);

        issue(8'd4, 8'd5);
        await_done("4x5 b2b", 16'd20, 8'h00, 1'b1, 8'd2, 8'd3);
        await_done("2x3 b2b", 16'd6, 8'h00, 1'b0, '0, '0);
        idle_watch("2x3 b2b", 3, 16'd6);

        // Reset during iteration 4 discards the operation
        issue(8'd200, 8'd3);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrun rst busy", 32'(busy), 32'd0);
        check("midrun rst done", 32'(done), 32'd0);
        check("midrun rst product", 32'(product), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        idle_watch("after rst", 4, 16'd0);

        issue(8'd6, 8'd7);
        await_done("6x7", 16'd42, 8'h00, 1'b0, '0, '0);

`ifdef SEQ_MULT_SIGNED_EN
        issue(8'hFD, 8'd5);
        await_done("s -3x5", 16'hFFF1, 8'h00, 1'b0, '0, '0);
        issue(8'h80, 8'h80);
        await_done("s -128x-128", 16'h4000, 8'h00, 1'b0, '0, '0);
        issue(8'h80, 8'h7F);
        await_done("s -128x127", 16'hC080, 8'h00, 1'b0, '0, '0);
`else
        issue(8'hFD, 8'd5);
        await_done("u 253x5", 16'h04F1, 8'h00, 1'b0, '0, '0);
        issue(8'h80, 8'h80);
        await_done("u 128x128", 16'h4000, 8'h00, 1'b0, '0, '0);
        issue(8'h80, 8'h7F);
        await_done("u 128x127", 16'h3F80, 8'h00, 1'b0, '0, '0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_mult.md
# seq_mult

Parametrised sequential shift-and-add binary multiplier. It takes two WIDTH-bit operands under a start/done handshake and produces a 2·WIDTH-bit product after WIDTH iterations. It is the multi-bit, clocked successor to the single-bit adder cells in the binary multiplier datapath, and it trades latency for area: one adder is reused for every partial product.

## Interface
- WIDTH, 8: operand width in bits; legal range 2..32.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request pulse; accepted only when the block is not busy.
- a  in  WIDTH  multiplicand; sampled on the accepting edge.
- b  in  WIDTH  multiplier; sampled on the accepting edge.
- busy  out  1  high while an operation is in progress (RUN state).
- done  out  1  one-cycle pulse; product is valid from this cycle on.
- product  out  2·WIDTH  result; holds until the next done.

## Operation
- States: IDLE, RUN, DONE.
- IDLE or DONE with start=1 (accept):
  - latch a into mcand and b into mplier;
  - clear acc_hi and the counter;
  - go to RUN.
- RUN, once per cycle:
  - if mplier[0]=1, form {carry, sum} = acc_hi + mcand (WIDTH+1 bits), else {0, acc_hi};
  - shift {carry, sum, mplier} right by one into {acc_hi, mplier};
  - increment the counter;
  - after the WIDTH-th iteration, register product = {acc_hi, mplier} and go to DONE.
- DONE: done=1 for exactly one cycle.
  - start=1 in this cycle is accepted (back-to-back operation) and the state goes to RUN.
  - Otherwise the state goes to IDLE.
- start while in RUN is ignored. Operands and product are unaffected.
- The carry out of the adder is never lost. The product is exact for all operand pairs; there is no overflow.
- Reset (any state, including mid-RUN): state=IDLE, busy=0, done=0, product=0, internal registers=0. The in-flight operation is discarded.

## Timing
- The accepting edge is E. RUN spans edges E+1 .. E+WIDTH.
- After edge E+WIDTH: done=1 and product valid. Latency is WIDTH cycles from the accepting edge.
- busy is high from after E until after E+WIDTH−1, i.e. WIDTH cycles, and low in the DONE cycle.
- Throughput: one result per WIDTH+1 cycles using back-to-back starts.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- SEQ_MULT_SIGNED_EN defined: operands and product are two's complement.
  - On accept, a and b are replaced by their magnitudes and neg = a[MSB] ^ b[MSB] is recorded.
  - On the final iteration the product is negated if neg=1.
  - −2^(WIDTH−1) is handled exactly; its magnitude fits in WIDTH unsigned bits.
  - Latency is unchanged.
- Not defined: operands and product are unsigned. The sign logic is absent.

## Structure
- Package seq_mult_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the counter width function ($clog2(WIDTH+1));
  - the WIDTH legality bounds.
- Sub-module seq_mult_add: WIDTH-bit ripple adder with carry out, built from bit-level full/half adder cells. It is instantiated once for the accumulate step.
- All control and the shift register live in seq_mult.

## Test plan
- WIDTH=8 unsigned, a=13, b=11, start for one cycle:
  - busy high 8 cycles;
  - done pulses exactly 8 cycles after the accepting edge;
  - product=143.
- a=255, b=255 → product=65025 (0xFE01), confirming carry propagation. Then a=0, b=0xA5 → product=0.
- start reasserted with a=1, b=1 at RUN iterations 3 and 5 of a 7×9 operation → ignored; product=63, followed by no extra done.
- Back-to-back: start held high through the DONE cycle with a=2, b=3 after a 4×5 operation:
  - product=20 with done;
  - next done 8 cycles later with product=6.
- rst pulsed at RUN iteration 4 → busy=0, done=0, product=0 immediately. A fresh 6×7 operation then yields 42 with normal latency.
- SEQ_MULT_SIGNED_EN, WIDTH=8:
  - −3×5 → 0xFFF1;
  - −128×−128 → 16384 (0x4000);
  - −128×127 → −16256 (0xC080).
